mem_ctrl_ws: RTL and testbench
==============================

Name: mem_ctrl_ws

Overview:
Parametrised successor to the single-port CPU memory controller. It sits between the Beta CPU data port and a synchronous single-port RAM, and replaces the bidirectional data bus with separate read and write paths. It adds a clocked FSM with synchronous reset, a programmable wait-state count, byte-lane write enables, and an out-of-range address error. It accepts one CPU request at a time under a Valid/Ready handshake.

Parameters:
DWIDTH, 32, data width in bits; must be a multiple of 8.
AWIDTH, 8, RAM word-address width.
MEMDEPTH, 256, number of implemented words; must be at most 2^AWIDTH.
WAIT_CYCLES, 2, extra idle cycles after each access, range 0..255.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
Valid  in  1  CPU request valid.
RW  in  1  1 = read, 0 = write.
Addr_in  in  AWIDTH  CPU word address.
Wdata_in  in  DWIDTH  CPU write data.
Be_in  in  DWIDTH/8  CPU byte-lane enables, used for writes.
Ready  out  1  controller idle; result of the last request is valid.
Rdata  out  DWIDTH  read result; held until the next read completes.
Err  out  1  last request was out of range.
Addr  out  AWIDTH  RAM address.
rdEn  out  1  RAM read enable.
wrEn  out  1  RAM write enable.
Ram_wdata  out  DWIDTH  RAM write data.
Ram_be  out  DWIDTH/8  RAM byte-lane write enables.
Ram_rdata  in  DWIDTH  RAM read data, valid the cycle after rdEn.

Behaviour:
- Reset: sampled at a rising edge and overrides everything, including mid-operation.
  - Next state is IDLE.
  - Ready=1, rdEn=0, wrEn=0, Err=0.
  - Addr, Rdata, Ram_wdata and Ram_be are all 0; the wait counter is 0.
  - Any in-flight request is dropped; no RAM enable is asserted after the reset edge.
- FSM states: IDLE, ACCESS, LATCH, WAIT, ERROR. All outputs are registered.
- IDLE:
  - Ready=1.
  - Acceptance is an edge with Valid=1 and Ready=1. At that edge register Addr<=Addr_in, the RW copy, Ram_wdata<=Wdata_in and Ram_be<=Be_in, and clear Err.
  - If Addr_in >= MEMDEPTH: go to ERROR; rdEn and wrEn stay 0.
  - Otherwise: go to ACCESS, with rdEn<=RW and wrEn<=~RW.
  - Ready<=0 in both cases.
- ACCESS: lasts exactly 1 cycle with the enables high. Next state is LATCH; rdEn and wrEn go to 0.
- LATCH: lasts 1 cycle.
  - For a read, Rdata<=Ram_rdata at the end of the cycle.
  - For a write, Rdata is unchanged.
  - Next state: if WAIT_CYCLES=0 go to IDLE with Ready<=1; otherwise go to WAIT and load the counter with WAIT_CYCLES-1.
- WAIT: decrement the counter each cycle. When the counter is 0, go to IDLE with Ready<=1.
- ERROR: lasts 1 cycle. Next state is IDLE with Ready<=1 and Err<=1. Rdata is unchanged.
- Err holds until the next acceptance.
- Latency, from acceptance edge E0 to the edge where Ready returns to 1:
  - Valid address: 2+WAIT_CYCLES cycles.
  - Out-of-range address: 1 cycle.
- Handshake rules:
  - Valid while Ready=0 is ignored; there is no queuing.
  - Addr_in, Wdata_in and Be_in need only be stable at the acceptance edge.
  - Back-to-back: Valid held high is accepted again on the same edge that Ready is sampled as 1. The minimum request spacing is therefore 3+WAIT_CYCLES cycles.
- RAM side:
  - rdEn and wrEn are never high together.
  - Addr, Ram_wdata and Ram_be are stable from acceptance until the next acceptance.
  - A write with Be_in=0 still pulses wrEn, with Ram_be=0.

Test Plan:
1. Reset behaviour: assert rst for 2 cycles -> Ready=1, Err=0, rdEn=0, wrEn=0, Addr=0, Rdata=0. Then assert rst while in WAIT -> the next edge gives IDLE, Ready=1, enables 0.
2. Write then read, WAIT_CYCLES=2:
   - Write Addr_in=0x10, Wdata_in=0xDEADBEEF, Be_in=4'hF -> wrEn high for exactly 1 cycle with Addr=0x10; Ready low for 4 cycles.
   - Read 0x10 -> rdEn pulses for 1 cycle; Rdata=0xDEADBEEF when Ready rises.
3. Byte lanes: write 0x11223344 to address 5 with Be_in=4'b0101 over 0xAAAAAAAA -> Ram_be=4'b0101 during wrEn; a readback gives 0xAA22AA44.
4. Out of range, MEMDEPTH=200: read 0xC8 -> rdEn and wrEn never assert; Ready low for 1 cycle; Err=1 and Rdata unchanged. The next valid request clears Err at acceptance.
5. WAIT_CYCLES=0 with Valid held high for 3 reads (addresses 1, 2, 3) -> accepted every 3 cycles; Ready low for 2 cycles each; Rdata sequence matches RAM contents.
6. Valid pulsed while Ready=0 with Addr_in=0x33 -> ignored; Addr stays at the in-flight address and no extra enable pulse appears.

Source files
------------

// File: rtl/mem_ctrl_ws.sv
// mem_ctrl_ws: wait-state memory controller between the Beta CPU data port
// and a synchronous single-port RAM. It takes one CPU request at a time
// under a Valid/Ready handshake. Each access drives the RAM for one cycle,
// latches read data in the next cycle, and then holds the controller busy
// for WAIT_CYCLES idle cycles. A word address at or above MEMDEPTH is never
// sent to the RAM. Instead it is reported on Err.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   Valid, RW             CPU request strobe and direction (1 = read)
//   Addr_in, Wdata_in     CPU word address and write data
//   Be_in                 CPU byte-lane enables (writes only)
//   Ready                 controller idle; last result is valid
//   Rdata                 last read result, held until the next read completes
//   Err                   last request was out of range
//   Addr, rdEn, wrEn      RAM address and one-cycle enables
//   Ram_wdata, Ram_be     RAM write data and byte-lane write enables
//   Ram_rdata             RAM read data, valid the cycle after rdEn

`timescale 1ns/1ps

module mem_ctrl_ws #(
    parameter int DWIDTH      = 32,
    parameter int AWIDTH      = 8,
    parameter int MEMDEPTH    = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Valid,
    input  logic                  RW,
    input  logic [AWIDTH-1:0]     Addr_in,
    input  logic [DWIDTH-1:0]     Wdata_in,
    input  logic [DWIDTH/8-1:0]   Be_in,
    output logic                  Ready,
    output logic [DWIDTH-1:0]     Rdata,
    output logic                  Err,
    output logic [AWIDTH-1:0]     Addr,
    output logic                  rdEn,
    output logic                  wrEn,
    output logic [DWIDTH-1:0]     Ram_wdata,
    output logic [DWIDTH/8-1:0]   Ram_be,
    input  logic [DWIDTH-1:0]     Ram_rdata
);

    // The counter is loaded with one less than the wait count. Its zero
    // cycle is then the last WAIT cycle.
    localparam logic [7:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 8'(WAIT_CYCLES - 1) : 8'd0;

    // One extra bit lets MEMDEPTH == 2**AWIDTH compare correctly.
    localparam logic [AWIDTH:0] DEPTH_LIMIT = (AWIDTH+1)'(MEMDEPTH);

    typedef enum logic [2:0] {
        IDLE,
        ACCESS,
        LATCH,
        WAIT,
        ERROR
    } state_t;

    state_t              state, state_n;
    logic                rw_q, rw_n;
    logic [7:0]          wait_cnt, wait_cnt_n;
    logic                ready_n;
    logic [DWIDTH-1:0]   rdata_n;
    logic                err_n;
    logic [AWIDTH-1:0]   addr_n;
    logic                rd_en_n, wr_en_n;
    logic [DWIDTH-1:0]   wdata_n;
    logic [DWIDTH/8-1:0] be_n;

    // Next-state and next-output logic. Every output is registered, so this
    // block computes the value each register takes at the coming edge. The
    // RAM enables default to 0, which makes them one-cycle pulses.
    always_comb begin
        state_n    = state;
        rw_n       = rw_q;
        wait_cnt_n = wait_cnt;
        ready_n    = Ready;
        rdata_n    = Rdata;
        err_n      = Err;
        addr_n     = Addr;
        rd_en_n    = 1'b0;
        wr_en_n    = 1'b0;
        wdata_n    = Ram_wdata;
        be_n       = Ram_be;

        case (state)
            IDLE: begin
                if (Valid && Ready) begin
                    addr_n  = Addr_in;
                    rw_n    = RW;
                    wdata_n = Wdata_in;
                    be_n    = Be_in;
                    err_n   = 1'b0;
                    ready_n = 1'b0;
                    if ({1'b0, Addr_in} >= DEPTH_LIMIT) begin
                        state_n = ERROR;
                    end else begin
                        state_n = ACCESS;
                        rd_en_n = RW;
                        wr_en_n = ~RW;
                    end
                end
            end
            ACCESS: begin
                state_n = LATCH;
            end
            LATCH: begin
                // The RAM presents read data during this cycle.
                if (rw_q) begin
                    rdata_n = Ram_rdata;
                end
                if (WAIT_CYCLES == 0) begin
                    state_n = IDLE;
                    ready_n = 1'b1;
                end else begin
                    state_n    = WAIT;
                    wait_cnt_n = WAIT_LOAD;
                end
            end
            WAIT: begin
                if (wait_cnt == 8'd0) begin
                    state_n = IDLE;
                    ready_n = 1'b1;
                end else begin
                    wait_cnt_n = wait_cnt - 8'd1;
                end
            end
            ERROR: begin
                state_n = IDLE;
                ready_n = 1'b1;
                err_n   = 1'b1;
            end
            default: begin
                state_n = IDLE;
                ready_n = 1'b1;
            end
        endcase
    end

    // State and output registers. Reset drops any in-flight request and
    // clears every RAM-facing register. As a result, no enable survives the
    // reset edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rw_q      <= 1'b0;
            wait_cnt  <= 8'd0;
            Ready     <= 1'b1;
            Rdata     <= '0;
            Err       <= 1'b0;
            Addr      <= '0;
            rdEn      <= 1'b0;
            wrEn      <= 1'b0;
            Ram_wdata <= '0;
            Ram_be    <= '0;
        end else begin
            state     <= state_n;
            rw_q      <= rw_n;
            wait_cnt  <= wait_cnt_n;
            Ready     <= ready_n;
            Rdata     <= rdata_n;
            Err       <= err_n;
            Addr      <= addr_n;
            rdEn      <= rd_en_n;
            wrEn      <= wr_en_n;
            Ram_wdata <= wdata_n;
            Ram_be    <= be_n;
        end
    end

endmodule

// File: tb/tb_mem_ctrl_ws.sv
// tb_mem_ctrl_ws: self-checking bench for mem_ctrl_ws.
// dut  : WAIT_CYCLES=2, MEMDEPTH=200, attached to a byte-lane RAM model
// dut0 : WAIT_CYCLES=0, MEMDEPTH=256, attached to a read-only pattern RAM
// Both instances share clk and rst.

`timescale 1ns/1ps

module tb_mem_ctrl_ws;

    localparam int DEPTH = 200;
    localparam int WAITS = 2;

    logic        clk = 1'b0;
    logic        rst;

    logic        valid, rw;
    logic [7:0]  addr_in;
    logic [31:0] wdata_in;
    logic [3:0]  be_in;
    logic        ready, err, rd_en, wr_en;
    logic [31:0] rdata, ram_wdata;
    logic [7:0]  addr;
    logic [3:0]  ram_be;
    logic [31:0] ram_rdata = 32'h0;

    logic        valid2, rw2;
    logic [7:0]  addr_in2;
    logic [31:0] wdata_in2;
    logic [3:0]  be_in2;
    logic        ready2, err2, rd_en2, wr_en2;
    logic [31:0] rdata2, ram_wdata2;
    logic [7:0]  addr2;
    logic [3:0]  ram_be2;
    logic [31:0] ram_rdata2 = 32'h0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_ctrl_ws #(.DWIDTH(32), .AWIDTH(8), .MEMDEPTH(DEPTH), .WAIT_CYCLES(WAITS)) dut (
        .clk(clk), .rst(rst), .Valid(valid), .RW(rw), .Addr_in(addr_in),
        .Wdata_in(wdata_in), .Be_in(be_in), .Ready(ready), .Rdata(rdata),
        .Err(err), .Addr(addr), .rdEn(rd_en), .wrEn(wr_en),
        .Ram_wdata(ram_wdata), .Ram_be(ram_be), .Ram_rdata(ram_rdata)
    );

    mem_ctrl_ws #(.DWIDTH(32), .AWIDTH(8), .MEMDEPTH(256), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .Valid(valid2), .RW(rw2), .Addr_in(addr_in2),
        .Wdata_in(wdata_in2), .Be_in(be_in2), .Ready(ready2), .Rdata(rdata2),
        .Err(err2), .Addr(addr2), .rdEn(rd_en2), .wrEn(wr_en2),
        .Ram_wdata(ram_wdata2), .Ram_be(ram_be2), .Ram_rdata(ram_rdata2)
    );

    // Synchronous RAM behind dut, with byte-lane writes and one-cycle read latency.
    logic [31:0] ram1 [256] = '{default: 32'h0};

    always @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_be[b]) ram1[addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
        end
        if (rd_en) ram_rdata <= ram1[addr];
    end

    // Read-only RAM behind dut0, with contents derived from the address.
    function automatic logic [31:0] pat(input logic [7:0] a);
        return {8'hC0, a, ~a, 8'h5A};
    endfunction

    always @(posedge clk) begin
        if (rd_en2) ram_rdata2 <= pat(addr2);
    end

    // Bus monitor for dut. It counts enable pulses and records
    // RAM-side values that break the contract of the current request.
    int          rd_cnt = 0, wr_cnt = 0, both_cnt = 0, lane_bad = 0, addr_bad = 0;
    logic [7:0]  exp_addr = 8'h0;
    logic [3:0]  exp_be = 4'h0;
    logic [31:0] exp_wdata = 32'h0;

    always @(negedge clk) begin
        if (rd_en === 1'b1) rd_cnt++;
        if (wr_en === 1'b1) wr_cnt++;
        if (rd_en === 1'b1 && wr_en === 1'b1) both_cnt++;
        if (wr_en === 1'b1 && (ram_be !== exp_be || ram_wdata !== exp_wdata)) lane_bad++;
        if (ready === 1'b0 && rst === 1'b0 && addr !== exp_addr) addr_bad++;
    end

    // Reference model: a word array plus the last read result. Each
    // request's outcome follows directly from the range rule and the latency.
    logic [31:0] ref_mem [256] = '{default: 32'h0};
    logic [31:0] ref_rdata = 32'h0;

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{be[b]}};
        return m;
    endfunction

    typedef struct {
        logic        rw;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        inject;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[11];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drives one request into dut from a negedge while dut is idle. It
    // returns the number of edges from acceptance until Ready is back, and
    // Err as seen just after acceptance. With inject set, it pulses Valid at
    // 0x33 while dut is busy.
    task automatic applyStimulus(input logic r, input logic [7:0] a, input logic [31:0] d,
                                 input logic [3:0] be, input logic inject,
                                 output int lat, output logic err_at_accept);
        exp_addr  = a;
        exp_be    = be;
        exp_wdata = d;
        valid     = 1'b1;
        rw        = r;
        addr_in   = a;
        wdata_in  = d;
        be_in     = be;
        @(posedge clk);
        @(negedge clk);
        err_at_accept = err;
        valid    = 1'b0;
        rw       = 1'($urandom);
        addr_in  = 8'($urandom);
        wdata_in = $urandom;
        be_in    = 4'($urandom);
        lat = 0;
        while (ready !== 1'b1 && lat < 20) begin
            if (inject && lat == 1) begin
                valid   = 1'b1;
                addr_in = 8'h33;
            end else begin
                valid = 1'b0;
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        valid = 1'b0;
    endtask

    task automatic runVector(input vec_t v);
        int   lat, rd0, wr0, both0, lane0, addr0;
        logic ea;
        rd0 = rd_cnt; wr0 = wr_cnt; both0 = both_cnt; lane0 = lane_bad; addr0 = addr_bad;
        applyStimulus(v.rw, v.addr, v.wdata, v.be, v.inject, lat, ea);
        checkOutput("latency", lat, v.exp_lat);
        checkOutput("err_clear_at_accept", ea, 1'b0);
        checkOutput("err", err, v.exp_err);
        checkOutput("rdata", rdata, v.exp_rdata);
        checkOutput("rd_pulses", rd_cnt - rd0, (!v.exp_err && v.rw) ? 1 : 0);
        checkOutput("wr_pulses", wr_cnt - wr0, (!v.exp_err && !v.rw) ? 1 : 0);
        checkOutput("enables_overlap", both_cnt - both0, 0);
        checkOutput("lane_data", lane_bad - lane0, 0);
        checkOutput("addr_hold", addr_bad - addr0, 0);
        checkOutput("addr_after", addr, v.addr);
        checkOutput("be_after", ram_be, v.be);
    endtask

    // Applies a request to the reference model.
    task automatic modelRequest(input logic r, input logic [7:0] a, input logic [31:0] d,
                                input logic [3:0] be);
        if (a < DEPTH) begin
            if (r) ref_rdata = ref_mem[a];
            else   ref_mem[a] = (ref_mem[a] & ~lane_mask(be)) | (d & lane_mask(be));
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    initial begin
        int   low;
        vec_t v;

        vecs[0]  = '{1'b0, 8'h10, 32'hDEADBEEF, 4'hF, 1'b0, 32'h00000000, 1'b0, 4};
        vecs[1]  = '{1'b1, 8'h10, 32'h0,        4'hF, 1'b0, 32'hDEADBEEF, 1'b0, 4};
        vecs[2]  = '{1'b0, 8'h05, 32'hAAAAAAAA, 4'hF, 1'b0, 32'hDEADBEEF, 1'b0, 4};
        vecs[3]  = '{1'b0, 8'h05, 32'h11223344, 4'h5, 1'b1, 32'hDEADBEEF, 1'b0, 4};
        vecs[4]  = '{1'b1, 8'h05, 32'h0,        4'h0, 1'b1, 32'hAA22AA44, 1'b0, 4};
        vecs[5]  = '{1'b1, 8'hC8, 32'h0,        4'hF, 1'b0, 32'hAA22AA44, 1'b1, 1};
        vecs[6]  = '{1'b0, 8'hFF, 32'h01020304, 4'hF, 1'b0, 32'hAA22AA44, 1'b1, 1};
        vecs[7]  = '{1'b1, 8'hC7, 32'h0,        4'hF, 1'b0, 32'h00000000, 1'b0, 4};
        vecs[8]  = '{1'b0, 8'h20, 32'hCAFEF00D, 4'hF, 1'b0, 32'h00000000, 1'b0, 4};
        vecs[9]  = '{1'b0, 8'h20, 32'h12345678, 4'h0, 1'b0, 32'h00000000, 1'b0, 4};
        vecs[10] = '{1'b1, 8'h20, 32'h0,        4'hF, 1'b0, 32'hCAFEF00D, 1'b0, 4};

        rst = 1'b1;
        valid = 1'b0; rw = 1'b0; addr_in = 8'h0; wdata_in = 32'h0; be_in = 4'h0;
        valid2 = 1'b0; rw2 = 1'b0; addr_in2 = 8'h0; wdata_in2 = 32'h0; be_in2 = 4'h0;

        // Reset held for two cycles.
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("reset_ready", ready, 1'b1);
        checkOutput("reset_err", err, 1'b0);
        checkOutput("reset_rden", rd_en, 1'b0);
        checkOutput("reset_wren", wr_en, 1'b0);
        checkOutput("reset_addr", addr, 8'h0);
        checkOutput("reset_rdata", rdata, 32'h0);
        checkOutput("reset_ram_wdata", ram_wdata, 32'h0);
        checkOutput("reset_ram_be", ram_be, 4'h0);
        checkOutput("reset_ready2", ready2, 1'b1);

        // Directed vectors.
        $display("[TB] directed table");
        foreach (vecs[i]) begin
            runVector(vecs[i]);
            modelRequest(vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].be);
        end

        // Reset while in WAIT, just after the read data was latched.
        $display("[TB] reset during WAIT");
        exp_addr = 8'h10; valid = 1'b1; rw = 1'b1; addr_in = 8'h10;
        @(posedge clk); @(negedge clk); valid = 1'b0;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        checkOutput("wait_busy", ready, 1'b0);
        checkOutput("wait_latched_rdata", rdata, 32'hDEADBEEF);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        checkOutput("wait_rst_ready", ready, 1'b1);
        checkOutput("wait_rst_rden", rd_en, 1'b0);
        checkOutput("wait_rst_wren", wr_en, 1'b0);
        checkOutput("wait_rst_addr", addr, 8'h0);
        checkOutput("wait_rst_rdata", rdata, 32'h0);
        ref_rdata = 32'h0;

        // Reset while the read enable is high: the pulse must not continue,
        // and no data is latched afterwards.
        $display("[TB] reset during ACCESS");
        exp_addr = 8'h05; valid = 1'b1; rw = 1'b1; addr_in = 8'h05;
        @(posedge clk); @(negedge clk); valid = 1'b0;
        checkOutput("access_rden", rd_en, 1'b1);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        checkOutput("access_rst_rden", rd_en, 1'b0);
        checkOutput("access_rst_ready", ready, 1'b1);
        @(posedge clk); @(negedge clk);
        checkOutput("access_rst_quiet", {rd_en, wr_en}, 2'b00);
        checkOutput("access_rst_rdata", rdata, 32'h0);

        // Randomized requests checked against the reference model.
        $display("[TB] random requests");
        for (int n = 0; n < 40; n++) begin
            v.rw      = 1'($urandom_range(0, 1));
            v.addr    = 8'($urandom_range(0, 219));
            v.wdata   = $urandom;
            v.be      = 4'($urandom);
            v.inject  = ($urandom_range(0, 3) == 0);
            v.exp_err = (v.addr >= DEPTH);
            v.exp_lat = v.exp_err ? 1 : 2 + WAITS;
            modelRequest(v.rw, v.addr, v.wdata, v.be);
            v.exp_rdata = ref_rdata;
            runVector(v);
        end

        // Back-to-back reads on dut0 with Valid held high. Each read should
        // be accepted every 3 cycles, with Ready low for 2.
        $display("[TB] back-to-back, zero wait states");
        valid2 = 1'b1; rw2 = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            addr_in2 = 8'(k);
            @(posedge clk); @(negedge clk);
            checkOutput("b2b_accept", ready2, 1'b0);
            checkOutput("b2b_rden", rd_en2, 1'b1);
            checkOutput("b2b_addr", addr2, 8'(k));
            low = 1;
            while (ready2 !== 1'b1 && low < 10) begin
                @(posedge clk); @(negedge clk);
                if (ready2 !== 1'b1) low++;
            end
            checkOutput("b2b_low_cycles", low, 2);
            checkOutput("b2b_rdata", rdata2, pat(8'(k)));
        end
        valid2 = 1'b0;
        @(posedge clk); @(negedge clk);
        checkOutput("b2b_idle_ready", ready2, 1'b1);
        checkOutput("b2b_idle_rden", rd_en2, 1'b0);
        checkOutput("b2b_err", err2, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
